// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Optional macro MULTICYCLE_ILLEGAL_TRAP_EN: unrecognised opcodes enter an absorbing TRAP state.
module multicycle_main_fsm #(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] Aluop,
    output logic       illegal,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    state_t     state;
    state_t     next_state;
    state_t     cur;
    logic [1:0] hold;
    logic       hold_active;
    logic       pcw_raw;
    logic       irw_raw;
    logic       memw_raw;
    logic       regw_raw;

    // While reset is held, outputs decode as if in FETCH regardless of the register.
    assign cur         = rst_n ? state : FETCH;
    assign hold_active = (hold != 2'd0);
    assign state_o     = cur;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
            hold  <= 2'(RESET_PC_HOLD);
        end else begin
            state <= next_state;
            if (hold_active)
                hold <= hold - 2'd1;
        end
    end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            illegal_q <= 1'b0;
        else if (next_state == TRAP)
            illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Memory handshake: FETCH, MEMREAD and MEMWRITE repeat every cycle until
    // mem_ready is sampled high at a rising edge, then advance.
    // FETCH also waits out the post-reset hold so no instruction is skipped.
    always_comb begin
        next_state = state;
        case (state)
            FETCH:    if (mem_ready && !hold_active) next_state = DECODE;
            DECODE: begin
                case (op)
                    7'b0000011,
                    7'b0100011: next_state = MEMADR;
                    7'b0110011: next_state = EXECUTER;
                    7'b0010011: next_state = EXECUTEI;
                    7'b1100011: next_state = BEQ;
                    7'b1101111: next_state = JAL;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    default:    next_state = TRAP;
`else
                    default:    next_state = FETCH;
`endif
                endcase
            end
            MEMADR:   next_state = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready) next_state = MEMWB;
            MEMWB:    next_state = FETCH;
            MEMWRITE: if (mem_ready) next_state = FETCH;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BEQ:      next_state = FETCH;
            JAL:      next_state = ALUWB;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            TRAP:     next_state = TRAP;
`else
            TRAP:     next_state = FETCH;
`endif
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        pcw_raw   = 1'b0;
        irw_raw   = 1'b0;
        memw_raw  = 1'b0;
        regw_raw  = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        Aluop     = 2'b00;
        case (cur)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pcw_raw   = mem_ready;
                irw_raw   = mem_ready;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                regw_raw  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                memw_raw = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                Aluop   = 2'b10;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                Aluop   = 2'b10;
            end
            ALUWB:    regw_raw = 1'b1;
            BEQ: begin
                ALUSrcA = 2'b10;
                Aluop   = 2'b01;
                pcw_raw = zero;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pcw_raw = 1'b1;
            end
            default: ;
        endcase
        PCWrite  = pcw_raw & rst_n & ~hold_active;
        IRWrite  = irw_raw & rst_n & ~hold_active;
        MemWrite = memw_raw & rst_n;
        RegWrite = regw_raw & rst_n;
    end

    always_comb begin
        case (op)
            7'b0100011: ImmSrc = 2'b01;
            7'b1100011: ImmSrc = 2'b10;
            7'b1101111: ImmSrc = 2'b11;
            default:    ImmSrc = 2'b00;
        endcase
    end

endmodule
